// File: rtl/top_register.sv
// WIDTH-bit parallel-load register: synchronous active-high reset, then load enable, else hold.
// q is taken straight from the state flops so no input reaches it combinationally.
module top_register #(
    parameter int unsigned            WIDTH       = 4,
    parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rest,
    input  logic             en,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // Compared against 1'b1 so an unknown enable falls through to "hold".
    always_comb begin
        q_d = q_q;
        if (rest) begin
            q_d = RESET_VALUE;
        end else if (en == 1'b1) begin
            q_d = D;
        end
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: tb/tb_top_register.sv
// Directed and mid-cycle stimulus for top_register; every rising edge is also
// checked against a small reference model once the first reset has been seen.
`timescale 1ns/1ps
module tb_top_register;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rest;
    logic             en;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] q;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] model_q;
    logic             model_valid = 1'b0;

    top_register #(
        .WIDTH      (WIDTH),
        .RESET_VALUE(4'b0000)
    ) dut (
        .clk (clk),
        .rest(rest),
        .en  (en),
        .D   (D),
        .q   (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: inputs never change on a rising edge, so sampling here is race-free.
    always @(posedge clk) begin
        if (rest === 1'b1) begin
            model_q     <= 4'b0000;
            model_valid <= 1'b1;
        end else if (en === 1'b1) begin
            model_q <= D;
        end
    end

    always @(posedge clk) begin
        #1;
        if (model_valid) chk("edge_model", 64'(q), 64'(model_q));
    end

    // Drive at the falling edge, check 2ns after the following rising edge.
    task automatic cycle(input logic r, input logic e, input logic [WIDTH-1:0] d,
                         input string tag, input logic [WIDTH-1:0] exp);
        @(negedge clk);
        rest = r;
        en   = e;
        D    = d;
        @(posedge clk);
        #2;
        chk(tag, 64'(q), 64'(exp));
        $display("txn %-12s rest=%b en=%b D=%b -> q=%b", tag, r, e, d, q);
    endtask

    initial begin
        rest = 1'b0;
        en   = 1'bx;
        D    = 4'b0000;
        repeat (2) @(posedge clk);

        cycle(1'b1, 1'bx, 4'b0001, "reset_en_x", 4'b0000);
        cycle(1'b1, 1'b1, 4'b0010, "rst_prio_1", 4'b0000);
        cycle(1'b1, 1'b1, 4'b0010, "rst_prio_2", 4'b0000);
        cycle(1'b1, 1'b0, 4'b0100, "rst_en0",    4'b0000);
        cycle(1'b0, 1'b0, 4'b0110, "post_rst_hold", 4'b0000);
        cycle(1'b0, 1'b1, 4'b1000, "load_1000",  4'b1000);
        cycle(1'b0, 1'b0, 4'b0001, "hold_0001",  4'b1000);
        cycle(1'b0, 1'b0, 4'b0110, "hold_0110",  4'b1000);
        cycle(1'b0, 1'b0, 4'b1111, "hold_1111",  4'b1000);
        cycle(1'b0, 1'bx, 4'b0111, "hold_en_x",  4'b1000);
        cycle(1'b1, 1'b1, 4'b0101, "rst_pulse",  4'b0000);
        cycle(1'b0, 1'b1, 4'b0101, "load_0101",  4'b0101);
        cycle(1'b0, 1'b1, 4'b1111, "load_1111",  4'b1111);
        cycle(1'b0, 1'b1, 4'b0000, "load_0000",  4'b0000);
        cycle(1'b0, 1'b1, 4'b1010, "load_1010",  4'b1010);

        // Reset asserted between edges must not move q until the next rising edge.
        @(negedge clk);
        rest = 1'b1;
        en   = 1'b0;
        #1;
        chk("rst_sync_wait", 64'(q), 64'(4'b1010));
        @(posedge clk);
        #2;
        chk("rst_sync_edge", 64'(q), 64'(4'b0000));
        $display("txn %-12s rest=1 en=0 -> q=%b", "rst_sync", q);

        // Enable and data swing mid-cycle; only the values present at the edge count.
        @(negedge clk);
        rest = 1'b0;
        en   = 1'b1;
        D    = 4'b1100;
        #3;
        en   = 1'b0;
        D    = 4'b0011;
        @(posedge clk);
        #2;
        chk("midcyc_drop", 64'(q), 64'(4'b0000));
        $display("txn %-12s en fell before edge -> q=%b", "midcyc_drop", q);

        @(negedge clk);
        en = 1'b0;
        D  = 4'b0110;
        #3;
        en = 1'b1;
        D  = 4'b1001;
        @(posedge clk);
        #2;
        en = 1'b0;
        D  = 4'b0111;
        #1;
        chk("midcyc_load", 64'(q), 64'(4'b1001));
        @(negedge clk);
        chk("midcyc_stable", 64'(q), 64'(4'b1001));
        $display("txn %-12s en rose before edge -> q=%b", "midcyc_load", q);

        // Pseudo-random activity at several points within each cycle; the edge monitor checks q.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rest = ($urandom_range(0, 7) == 0);
            en   = 1'($urandom);
            D    = 4'($urandom);
            #2;
            en   = 1'($urandom);
            D    = 4'($urandom);
            @(posedge clk);
            #3;
            rest = 1'($urandom);
            en   = 1'($urandom);
            D    = 4'($urandom);
            $display("txn rand%-8d q=%b model=%b", i, q, model_q);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
